// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ultrasonic ranger: periodic trigger, echo width capture and
// divider-free conversion to centimetres for the AUV obstacle-distance path.
module ultrasonic_ranger #(
  parameter int CLK_PER_US = 24,
  parameter int TRIG_US    = 10,
  parameter int US_PER_CM  = 58,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] dist_cm,
  output logic        dist_valid,
  output logic        timeout
);

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int PER_W = $clog2(PERIOD_US + 1);
  localparam int TMO_W = $clog2(TIMEOUT_US + 1);
  localparam int CM_W  = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_US - 1);
  localparam logic [PER_W-1:0] TRIG_LAST = PER_W'(TRIG_US - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_US - 1);
  localparam logic [CM_W-1:0]  CM_LAST   = CM_W'(US_PER_CM - 1);
  localparam logic [15:0]      CM_SAT    = 16'hFFFE;
  localparam logic [15:0]      DIST_TMO  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

  state_t state, next_state;

  logic             echo_meta, echo_s;
  logic [PRE_W-1:0] pre_cnt;
  logic [PER_W-1:0] period_us;
  logic [TMO_W-1:0] tmo_us;
  logic [CM_W-1:0]  us_cnt;
  logic [15:0]      cm_cnt;
  logic             us_tick;
  logic             cm_wrap;
  logic [15:0]      cm_inc;
  logic [15:0]      cm_now;
  logic             enter_trig, enter_wait, enter_meas;
  logic             load_dist, load_tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
    end
  end

  assign us_tick = (pre_cnt == PRE_LAST);
  assign cm_wrap = us_tick && (us_cnt == CM_LAST);
  assign cm_inc  = (cm_cnt == CM_SAT) ? CM_SAT : cm_cnt + 16'd1;
  // The tick landing on the closing edge still counts, so the result is an exact floor.
  assign cm_now  = cm_wrap ? cm_inc : cm_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    trig       = 1'b0;
    enter_trig = 1'b0;
    enter_wait = 1'b0;
    enter_meas = 1'b0;
    load_dist  = 1'b0;
    load_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          next_state = TRIG;
          enter_trig = 1'b1;
        end
      end
      TRIG: begin
        trig = 1'b1;
        if (us_tick && period_us == TRIG_LAST) begin
          next_state = WAIT_RISE;
          enter_wait = 1'b1;
        end
      end
      WAIT_RISE: begin
        if (echo_s) begin
          next_state = MEASURE;
          enter_meas = 1'b1;
        end else if (us_tick && tmo_us == TMO_LAST) begin
          next_state = GAP;
          load_tmo   = 1'b1;
        end
      end
      MEASURE: begin
        if (us_tick && tmo_us == TMO_LAST) begin
          next_state = GAP;
          load_tmo   = 1'b1;
        end else if (!echo_s) begin
          next_state = GAP;
          load_dist  = 1'b1;
        end
      end
      GAP: begin
        // Leaving on the wrapping tick makes trigger-to-trigger exactly one period.
        if (us_tick && period_us >= PER_LAST) begin
          if (enable) begin
            next_state = TRIG;
            enter_trig = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      period_us <= '0;
      tmo_us    <= '0;
      us_cnt    <= '0;
      cm_cnt    <= '0;
    end else begin
      if (enter_trig || us_tick) pre_cnt <= '0;
      else                       pre_cnt <= pre_cnt + PRE_W'(1);

      if (enter_trig)                      period_us <= '0;
      else if (state != IDLE && us_tick)   period_us <= period_us + PER_W'(1);

      if (enter_wait || enter_meas) tmo_us <= '0;
      else if ((state == WAIT_RISE || state == MEASURE) && us_tick)
        tmo_us <= tmo_us + TMO_W'(1);

      if (enter_meas) begin
        us_cnt <= '0;
        cm_cnt <= '0;
      end else if (state == MEASURE && us_tick) begin
        if (cm_wrap) begin
          us_cnt <= '0;
          cm_cnt <= cm_inc;
        end else begin
          us_cnt <= us_cnt + CM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dist_cm    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      dist_valid <= load_dist || load_tmo;
      timeout    <= load_tmo;
      if (load_tmo)       dist_cm <= DIST_TMO;
      else if (load_dist) dist_cm <= cm_now;
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger, run with shortened timing parameters.
module tb_ultrasonic_ranger;

  localparam int CLK_PER_US = 2;
  localparam int TRIG_US    = 10;
  localparam int US_PER_CM  = 58;
  localparam int TIMEOUT_US = 1000;
  localparam int PERIOD_US  = 2200;
  localparam int TRIG_CYC   = TRIG_US * CLK_PER_US;
  localparam int PERIOD_CYC = PERIOD_US * CLK_PER_US;
  localparam int TMO_CYC    = TIMEOUT_US * CLK_PER_US;

  logic        clk = 1'b0;
  logic        rst, enable, echo;
  logic        trig;
  logic [15:0] dist_cm;
  logic        dist_valid, timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_seen = 0;
  int bad_valid = 0;

  typedef struct {
    int          delay_us;
    int          high_us;
    logic [15:0] exp_cm;
  } vec_t;

  vec_t vecs[5];

  ultrasonic_ranger #(
    .CLK_PER_US(CLK_PER_US),
    .TRIG_US   (TRIG_US),
    .US_PER_CM (US_PER_CM),
    .TIMEOUT_US(TIMEOUT_US),
    .PERIOD_US (PERIOD_US)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .echo      (echo),
    .trig      (trig),
    .dist_cm   (dist_cm),
    .dist_valid(dist_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dist_valid) valid_seen = valid_seen + 1;
    if ((dist_valid || timeout) && trig) bad_valid = bad_valid + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic waitTrigRise(input int budget, output int at_cyc);
    int n;
    n = 0;
    at_cyc = -1;
    while (!trig && n < budget) begin
      tick(1);
      n++;
    end
    if (trig) at_cyc = cyc;
    else begin
      checks++;
      failures++;
      $display("[TB] FAIL trig_wait: actual=no_rise required=rise_within_%0d", budget);
    end
  endtask

  task automatic countTrigHigh(output int hi);
    hi = 0;
    while (trig && hi < 4 * TRIG_CYC) begin
      hi++;
      tick(1);
    end
  endtask

  task automatic applyStimulus(input int delay_us, input int high_us);
    tick(delay_us * CLK_PER_US);
    echo = 1'b1;
    tick(high_us * CLK_PER_US);
    echo = 1'b0;
  endtask

  task automatic checkResult(input string name, input logic [15:0] exp_cm, input int v0);
    tick(1);
    checkOutput({name, "_lat1"}, dist_valid, 1'b0);
    tick(1);
    checkOutput({name, "_lat2"}, dist_valid, 1'b0);
    tick(1);
    checkOutput({name, "_valid"}, dist_valid, 1'b1);
    checkOutput({name, "_cm"}, dist_cm, exp_cm);
    checkOutput({name, "_tmo"}, timeout, 1'b0);
    tick(1);
    checkOutput({name, "_pulse"}, dist_valid, 1'b0);
    checkOutput({name, "_count"}, valid_seen - v0, 1);
  endtask

  task automatic checkTimeout(input string name);
    int v0;
    v0 = valid_seen;
    tick(TMO_CYC - 1);
    checkOutput({name, "_early"}, valid_seen - v0, 0);
    checkOutput({name, "_pre"}, dist_valid, 1'b0);
    tick(1);
    checkOutput({name, "_valid"}, dist_valid, 1'b1);
    checkOutput({name, "_flag"}, timeout, 1'b1);
    checkOutput({name, "_cm"}, dist_cm, 16'hFFFF);
    tick(1);
    checkOutput({name, "_pulse"}, {dist_valid, timeout}, 2'b00);
    checkOutput({name, "_hold"}, dist_cm, 16'hFFFF);
  endtask

  initial begin
    int prev_rise, rise, hi, v0, seen;

    vecs[0] = '{delay_us: 100, high_us: 580, exp_cm: 16'd10};
    vecs[1] = '{delay_us: 50,  high_us: 57,  exp_cm: 16'd0};
    vecs[2] = '{delay_us: 30,  high_us: 115, exp_cm: 16'd1};
    vecs[3] = '{delay_us: 200, high_us: 986, exp_cm: 16'd17};
    vecs[4] = '{delay_us: 5,   high_us: 116, exp_cm: 16'd2};

    rst = 1'b1;
    enable = 1'b0;
    echo = 1'b0;
    tick(3);
    checkOutput("rst_trig", trig, 1'b0);
    checkOutput("rst_cm", dist_cm, 16'd0);
    checkOutput("rst_valid", dist_valid, 1'b0);
    checkOutput("rst_tmo", timeout, 1'b0);

    // Disabled: echo activity must not cause triggers or results.
    rst = 1'b0;
    v0 = valid_seen;
    seen = 0;
    for (int i = 0; i < 2 * PERIOD_CYC; i++) begin
      if (i % 150 == 0) echo = ~echo;
      tick(1);
      if (trig) seen++;
    end
    echo = 1'b0;
    tick(4);
    checkOutput("idle_trig", seen, 0);
    checkOutput("idle_valid", valid_seen - v0, 0);

    enable = 1'b1;
    tick(1);
    checkOutput("enable_trig", trig, 1'b1);
    prev_rise = cyc;

    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        waitTrigRise(PERIOD_CYC + 10, rise);
        checkOutput($sformatf("period%0d", i), rise - prev_rise, PERIOD_CYC);
        prev_rise = rise;
      end
      countTrigHigh(hi);
      checkOutput($sformatf("trig_width%0d", i), hi, TRIG_CYC);
      v0 = valid_seen;
      applyStimulus(vecs[i].delay_us, vecs[i].high_us);
      checkResult($sformatf("vec%0d", i), vecs[i].exp_cm, v0);
    end

    // Echo never rises.
    waitTrigRise(PERIOD_CYC + 10, rise);
    checkOutput("period_tmo", rise - prev_rise, PERIOD_CYC);
    countTrigHigh(hi);
    checkTimeout("norise");

    // Echo stuck high across the trigger.
    waitTrigRise(PERIOD_CYC + 10, rise);
    echo = 1'b1;
    countTrigHigh(hi);
    checkTimeout("stuck");
    echo = 1'b0;

    // Enable dropped mid-measurement: result still delivered, then no more triggers.
    waitTrigRise(PERIOD_CYC + 10, rise);
    countTrigHigh(hi);
    tick(100 * CLK_PER_US);
    echo = 1'b1;
    tick(100);
    enable = 1'b0;
    v0 = valid_seen;
    tick(290 * CLK_PER_US - 100);
    echo = 1'b0;
    checkResult("dropen", 16'd5, v0);
    seen = 0;
    for (int i = 0; i < 2 * PERIOD_CYC; i++) begin
      tick(1);
      if (trig) seen++;
    end
    checkOutput("dropen_notrig", seen, 0);

    // Reset mid-measurement aborts with no result and restarts immediately.
    enable = 1'b1;
    tick(1);
    checkOutput("restart_trig", trig, 1'b1);
    countTrigHigh(hi);
    tick(100 * CLK_PER_US);
    echo = 1'b1;
    tick(200);
    v0 = valid_seen;
    rst = 1'b1;
    tick(1);
    checkOutput("abort_trig", trig, 1'b0);
    checkOutput("abort_cm", dist_cm, 16'd0);
    checkOutput("abort_valid", dist_valid, 1'b0);
    rst = 1'b0;
    echo = 1'b0;
    tick(1);
    checkOutput("abort_retrig", trig, 1'b1);
    tick(10);
    checkOutput("abort_noresult", valid_seen - v0, 0);

    checkOutput("valid_in_trig", bad_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
